demux_lanes_param: RTL and testbench
====================================

// Module: demux_lanes_param
// PURPOSE
//  Parametrised 1:RATIO word demultiplexer, one per input lane, in a single clock domain.
//  - Each lane collects RATIO consecutive valid words.
//  - The collected group is presented on RATIO parallel output slots for exactly one cycle.
//  - Sits between the serial lane receivers and the wide parallel datapath.
//  - Adds a flush mode that emits partial groups.
// PARAMETERS
//  WIDTH  8  bits per data word
//  LANES  2  number of independent input lanes (>=1)
//  RATIO  2  words gathered per lane into one output group (>=1); counter width = max(1,$clog2(RATIO))
// PORTS
//  clk        in   1              single clock, rising edge
//  reset      in   1              asynchronous, active-high
//  valid_in   in   LANES          valid_in[l] qualifies lane l word this cycle
//  data_in    in   LANES*WIDTH    lane l word at [l*WIDTH +: WIDTH]
//  flush      in   1              emit any partial groups on this edge
//  valid_out  out  LANES*RATIO    slot valid; lane l slot s at index l*RATIO+s
//  data_out   out  LANES*RATIO*WIDTH  slot data, same indexing, WIDTH bits per slot
//  group_out  out  LANES          1-cycle pulse: lane l emitted a group (full or flushed)
// BEHAVIOUR
//  - Reset (async, any time): valid_out=0, data_out=0, group_out=0, all lane counters=0, slot stores=0.
//    Reset mid-group discards the partial group; nothing is emitted afterwards for it.
//  - Per lane, per edge:
//    - valid_in[l]=1: word written to slot cnt[l] (slot 0 = oldest word); cnt[l] increments.
//    - valid_in[l]=0: cnt and stored slots hold; there is no timeout.
//  - Completion: at the edge where the word for slot RATIO-1 is sampled:
//    - that lane's outputs load all RATIO slots and valid_out for the lane is all ones.
//    - group_out[l]=1 and cnt[l] wraps to 0.
//    - Latency: the last word is visible on data_out after the same edge that sampled it.
//  - Outputs are registered and live exactly one cycle. On any edge without emission for
//    lane l, the lane's valid_out=0, data_out=0 (zero-fill), group_out[l]=0.
//  - Back-to-back groups: a new word at the edge after completion starts the next group
//    at slot 0. Output pulses are separated by at least RATIO-1 idle cycles at full rate.
//  - Flush at an edge, per lane:
//    - A partial group exists if cnt>0, or valid_in[l]=1 at that edge.
//    - If one exists, emit it: filled slots get valid_out=1 with their data; unfilled slots
//      get valid_out=0, data 0. Set group_out[l]=1 and cnt[l]=0.
//    - If the word sampled on the flush edge completes the group, it is a normal full emission.
//    - A lane with nothing pending emits nothing: all zeros, group_out=0.
//  - Lanes are fully independent; simultaneous completions on several lanes all emit on the same edge.
//  - RATIO=1: every valid word appears on slot 0 one edge later with valid_out=1; flush has no effect.
//  - No backpressure: downstream must capture on group_out. Every valid word is taken.
// TESTING (WIDTH=8, LANES=2, RATIO=2 unless noted)
//  1. Reset mid-group:
//     - Stimulus: lane0 valid 0xA1, then reset pulse, then 0xB1, 0xB2.
//     - Required: only {0xB1,0xB2} emitted; 0xA1 never appears.
//     - Async check: reset asserted between clock edges clears all outputs immediately.
//  2. Full-rate lane0 stream 0x11,0x22,0x33,0x44:
//     - Cycle 2: slot0=0x11, slot1=0x22, valid_out[1:0]=11, group_out[0]=1.
//     - Cycle 3: all zero.
//     - Cycle 4: slot0=0x33, slot1=0x44.
//  3. Gapped input on lane1:
//     - Stimulus: 0x5A, idle x3, 0x5B.
//     - Required: single emission {0x5A,0x5B} on the edge sampling 0x5B; outputs zero meanwhile.
//  4. Flush with partial group on lane0:
//     - Stimulus: 0x77, idle, flush=1.
//     - Required: slot0=0x77, valid_out[0]=1, valid_out[1]=0, slot1=0x00, group_out[0]=1.
//     - Required: lane1 idle, so group_out[1]=0.
//  5. Simultaneous activity:
//     - Stimulus: both lanes full rate; lane0 0x01,0x02; lane1 0xF1,0xF2.
//     - Required: same-edge emission; valid_out=4'b1111; data_out={F2,F1,02,01} (slot 3 down to slot 0).
//  6. RATIO=4, LANES=1:
//     - Stimulus: 0x10..0x13 at full rate.
//     - Required: one emission, slots 0..3 = 0x10..0x13.
//     - Follow-up: 0x20 then flush on the same edge as 0x21.
//     - Required: slots {0x20,0x21,0,0}, valid_out=4'b0011.

Source files
------------

// File: rtl/demux_lanes_param_if.sv
// Lane-side bus bundle for the 1:RATIO lane demultiplexer.
// The master drives lane words and flush and observes the grouped outputs.
// The slave (the demux) takes lane words and produces the grouped outputs.
interface demux_lanes_param_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 2,
    parameter int RATIO = 2
);
    logic [LANES-1:0]             valid_in;
    logic [LANES*WIDTH-1:0]       data_in;
    logic                         flush;
    logic [LANES*RATIO-1:0]       valid_out;
    logic [LANES*RATIO*WIDTH-1:0] data_out;
    logic [LANES-1:0]             group_out;

    modport master (
        output valid_in,
        output data_in,
        output flush,
        input  valid_out,
        input  data_out,
        input  group_out
    );

    modport slave (
        input  valid_in,
        input  data_in,
        input  flush,
        output valid_out,
        output data_out,
        output group_out
    );
endinterface

// File: rtl/demux_lanes_param.sv
// Per-lane 1:RATIO word demultiplexer.
// Each lane gathers RATIO valid words into slot storage. A complete group,
// or a partial group when flush is asserted, is presented on registered
// output slots for exactly one cycle. Empty slots and idle cycles read zero.
module demux_lanes_param #(
    parameter int WIDTH = 8,
    parameter int LANES = 2,
    parameter int RATIO = 2
) (
    input logic                clk,
    input logic                reset,
    demux_lanes_param_if.slave bus
);
    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [CW-1:0]          cnt_q, cnt_d;
            logic [RATIO*WIDTH-1:0] store_q, store_d, store_w;
            logic [RATIO-1:0]       vout_q, vout_d;
            logic [RATIO*WIDTH-1:0] dout_q, dout_d;
            logic                   grp_q, grp_d;
            logic                   wr, full, pending, emit_full, emit_flush;
            logic [CW:0]            fill;
            logic [WIDTH-1:0]       word;

            assign word       = bus.data_in[gi*WIDTH +: WIDTH];
            assign wr         = bus.valid_in[gi];
            assign full       = wr && (cnt_q == LAST);
            assign pending    = (cnt_q != '0) || wr;
            assign emit_full  = full;
            // A word completing the group on a flush edge is a normal full emission.
            assign emit_flush = bus.flush && pending && !full;
            // Number of filled slots once this edge's word (if any) is included.
            assign fill       = {1'b0, cnt_q} + {{CW{1'b0}}, wr};

            // Slot storage view including the word sampled on this edge.
            always_comb begin
                store_w = store_q;
                for (int s = 0; s < RATIO; s++) begin
                    if (wr && (cnt_q == CW'(s))) begin
                        store_w[s*WIDTH +: WIDTH] = word;
                    end
                end
            end

            // Emission decode: only filled slots are marked valid, others read zero.
            always_comb begin
                vout_d = '0;
                dout_d = '0;
                grp_d  = emit_full || emit_flush;
                for (int s = 0; s < RATIO; s++) begin
                    if (emit_full || (emit_flush && (fill > (CW+1)'(s)))) begin
                        vout_d[s]                = 1'b1;
                        dout_d[s*WIDTH +: WIDTH] = store_w[s*WIDTH +: WIDTH];
                    end
                end
                cnt_d   = grp_d ? '0 : (cnt_q + CW'(wr));
                store_d = grp_d ? '0 : store_w;
            end

            // Lane state and one-cycle output registers.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q   <= '0;
                    store_q <= '0;
                    vout_q  <= '0;
                    dout_q  <= '0;
                    grp_q   <= 1'b0;
                end else begin
                    cnt_q   <= cnt_d;
                    store_q <= store_d;
                    vout_q  <= vout_d;
                    dout_q  <= dout_d;
                    grp_q   <= grp_d;
                end
            end

            assign bus.valid_out[gi*RATIO +: RATIO]             = vout_q;
            assign bus.data_out[gi*RATIO*WIDTH +: RATIO*WIDTH] = dout_q;
            assign bus.group_out[gi]                            = grp_q;
        end
    endgenerate
endmodule

// File: tb/tb_demux_lanes_param.sv
// Self-checking bench for demux_lanes_param: directed vector table,
// hand-written reset/flush sequences, and randomized traffic against a
// queue-based reference model.
module tb_demux_lanes_param;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    demux_lanes_param_if #(.WIDTH(8), .LANES(2), .RATIO(2)) bus_a ();
    demux_lanes_param_if #(.WIDTH(8), .LANES(1), .RATIO(4)) bus_b ();

    demux_lanes_param #(.WIDTH(8), .LANES(2), .RATIO(2)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave)
    );
    demux_lanes_param #(.WIDTH(8), .LANES(1), .RATIO(4)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0]  vin;
        logic [15:0] din;
        logic        fl;
        logic [3:0]  ev;
        logic [31:0] ed;
        logic [1:0]  eg;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step_a(input logic [1:0] vin, input logic [15:0] din, input logic fl);
        bus_a.valid_in = vin;
        bus_a.data_in  = din;
        bus_a.flush    = fl;
        @(posedge clk);
        @(negedge clk);
        bus_a.valid_in = '0;
        bus_a.data_in  = '0;
        bus_a.flush    = 1'b0;
    endtask

    task automatic check_a(input string tag, input logic [3:0] ev, input logic [31:0] ed,
                           input logic [1:0] eg);
        chk({tag, "_vout"}, 64'(bus_a.valid_out), 64'(ev));
        chk({tag, "_dout"}, 64'(bus_a.data_out), 64'(ed));
        chk({tag, "_grp"},  64'(bus_a.group_out), 64'(eg));
        $display("[TB] %s vout=%b dout=%h grp=%b", tag, bus_a.valid_out, bus_a.data_out,
                 bus_a.group_out);
    endtask

    task automatic step_b(input logic vin, input logic [7:0] din, input logic fl);
        bus_b.valid_in = vin;
        bus_b.data_in  = din;
        bus_b.flush    = fl;
        @(posedge clk);
        @(negedge clk);
        bus_b.valid_in = '0;
        bus_b.data_in  = '0;
        bus_b.flush    = 1'b0;
    endtask

    task automatic check_b(input string tag, input logic [3:0] ev, input logic [31:0] ed,
                           input logic eg);
        chk({tag, "_vout"}, 64'(bus_b.valid_out), 64'(ev));
        chk({tag, "_dout"}, 64'(bus_b.data_out), 64'(ed));
        chk({tag, "_grp"},  64'(bus_b.group_out), 64'(eg));
        $display("[TB] %s vout=%b dout=%h grp=%b", tag, bus_b.valid_out, bus_b.data_out,
                 bus_b.group_out);
    endtask

    function automatic vec_t mk(input logic [1:0] vin, input logic [15:0] din, input logic fl,
                                input logic [3:0] ev, input logic [31:0] ed, input logic [1:0] eg);
        vec_t v;
        v.vin = vin; v.din = din; v.fl = fl; v.ev = ev; v.ed = ed; v.eg = eg;
        return v;
    endfunction

    logic [7:0] mq [2][$];

    initial begin
        // Directed vectors: full-rate, gapped, flush, simultaneous, flush-on-completion.
        tbl.push_back(mk(2'b01, 16'h0011, 0, 4'b0000, 32'h0, 2'b00));
        tbl.push_back(mk(2'b01, 16'h0022, 0, 4'b0011, 32'h0000_2211, 2'b01));
        tbl.push_back(mk(2'b01, 16'h0033, 0, 4'b0000, 32'h0, 2'b00));
        tbl.push_back(mk(2'b01, 16'h0044, 0, 4'b0011, 32'h0000_4433, 2'b01));
        tbl.push_back(mk(2'b10, 16'h5A00, 0, 4'b0000, 32'h0, 2'b00));
        tbl.push_back(mk(2'b00, 16'h0000, 0, 4'b0000, 32'h0, 2'b00));
        tbl.push_back(mk(2'b00, 16'h0000, 0, 4'b0000, 32'h0, 2'b00));
        tbl.push_back(mk(2'b00, 16'h0000, 0, 4'b0000, 32'h0, 2'b00));
        tbl.push_back(mk(2'b10, 16'h5B00, 0, 4'b1100, 32'h5B5A_0000, 2'b10));
        tbl.push_back(mk(2'b01, 16'h0077, 0, 4'b0000, 32'h0, 2'b00));
        tbl.push_back(mk(2'b00, 16'h0000, 0, 4'b0000, 32'h0, 2'b00));
        tbl.push_back(mk(2'b00, 16'h0000, 1, 4'b0001, 32'h0000_0077, 2'b01));
        tbl.push_back(mk(2'b00, 16'h0000, 0, 4'b0000, 32'h0, 2'b00));
        tbl.push_back(mk(2'b11, 16'hF101, 0, 4'b0000, 32'h0, 2'b00));
        tbl.push_back(mk(2'b11, 16'hF202, 0, 4'b1111, 32'hF2F1_0201, 2'b11));
        tbl.push_back(mk(2'b01, 16'h0081, 0, 4'b0000, 32'h0, 2'b00));
        tbl.push_back(mk(2'b11, 16'h9182, 1, 4'b0111, 32'h0091_8281, 2'b11));
        tbl.push_back(mk(2'b00, 16'h0000, 1, 4'b0000, 32'h0, 2'b00));

        reset          = 1'b1;
        bus_a.valid_in = '0; bus_a.data_in = '0; bus_a.flush = 1'b0;
        bus_b.valid_in = '0; bus_b.data_in = '0; bus_b.flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_a("reset_a", 4'b0, 32'h0, 2'b0);
        check_b("reset_b", 4'b0, 32'h0, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            step_a(tbl[i].vin, tbl[i].din, tbl[i].fl);
            check_a($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].eg);
        end

        // Reset mid-group: lane0 holds 0xA1 while lane1 emits; async reset between edges.
        step_a(2'b11, 16'hC1A1, 1'b0);
        check_a("rst_pre0", 4'b0, 32'h0, 2'b00);
        step_a(2'b10, 16'hC200, 1'b0);
        check_a("rst_pre1", 4'b1100, 32'hC2C1_0000, 2'b10);
        #2 reset = 1'b1;
        #1 check_a("rst_async", 4'b0, 32'h0, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        step_a(2'b01, 16'h00B1, 1'b0);
        check_a("rst_b1", 4'b0, 32'h0, 2'b00);
        step_a(2'b01, 16'h00B2, 1'b0);
        check_a("rst_b2", 4'b0011, 32'h0000_B2B1, 2'b01);
        step_a(2'b00, 16'h0000, 1'b0);
        check_a("rst_idle", 4'b0, 32'h0, 2'b00);

        // RATIO=4, LANES=1 instance: full group, then flush on the second word.
        step_b(1'b1, 8'h10, 1'b0); check_b("r4_10", 4'b0, 32'h0, 1'b0);
        step_b(1'b1, 8'h11, 1'b0); check_b("r4_11", 4'b0, 32'h0, 1'b0);
        step_b(1'b1, 8'h12, 1'b0); check_b("r4_12", 4'b0, 32'h0, 1'b0);
        step_b(1'b1, 8'h13, 1'b0); check_b("r4_13", 4'b1111, 32'h1312_1110, 1'b1);
        step_b(1'b1, 8'h20, 1'b0); check_b("r4_20", 4'b0, 32'h0, 1'b0);
        step_b(1'b1, 8'h21, 1'b1); check_b("r4_21f", 4'b0011, 32'h0000_2120, 1'b1);
        step_b(1'b0, 8'h00, 1'b0); check_b("r4_idle", 4'b0, 32'h0, 1'b0);

        // Randomized traffic against a queue model: a lane emits once it holds
        // two words, or on flush while holding any.
        for (int n = 0; n < 500; n++) begin
            logic [1:0]  vin;
            logic [15:0] din;
            logic        fl;
            logic [3:0]  ev;
            logic [31:0] ed;
            logic [1:0]  eg;
            vin = 2'($urandom);
            din = 16'($urandom);
            fl  = ($urandom_range(0, 7) == 0);
            ev = '0; ed = '0; eg = '0;
            for (int l = 0; l < 2; l++) begin
                if (vin[l]) mq[l].push_back(din[l*8 +: 8]);
                if (mq[l].size() == 2 || (fl && mq[l].size() > 0)) begin
                    eg[l] = 1'b1;
                    for (int s = 0; s < mq[l].size(); s++) begin
                        ev[l*2+s]          = 1'b1;
                        ed[(l*2+s)*8 +: 8] = mq[l][s];
                    end
                    mq[l].delete();
                end
            end
            step_a(vin, din, fl);
            check_a($sformatf("rnd%0d", n), ev, ed, eg);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
